// File: rtl/max_search_stream.sv
// max_search_stream: streaming max/argmax search over a vector delivered `lanes` elements per beat.
//   clock_i, reset_n_i (async, active-low)
//   start_i/length_i   : begin a vector of length_i elements (0 or >number_of_data means number_of_data)
//   valid_i/data_i/ready_o : beat handshake, lane k at data_i[k*data_size +: data_size]
//   data_max_o/index_max_o/max_tree_done_o : result of the last completed vector, done is a level
module max_search_stream #(
  parameter int data_size      = 32,
  parameter int number_of_data = 10,
  parameter int lanes          = 2,
  parameter bit signed_mode    = 1'b0,
  localparam int LW = $clog2(number_of_data + 1),
  localparam int IW = (number_of_data > 1) ? $clog2(number_of_data) : 1
) (
  input  logic                       clock_i,
  input  logic                       reset_n_i,
  input  logic                       start_i,
  input  logic [LW-1:0]              length_i,
  input  logic                       valid_i,
  input  logic [lanes*data_size-1:0] data_i,
  output logic                       ready_o,
  output logic [data_size-1:0]       data_max_o,
  output logic [IW-1:0]              index_max_o,
  output logic                       max_tree_done_o
);
  localparam int CW = $clog2(number_of_data + lanes + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t               r_state;
  logic                 r_ready, r_done;
  logic [data_size-1:0] r_max, r_s1_val, r_acc_val;
  logic [IW-1:0]        r_idx, r_s1_idx, r_acc_idx;
  logic [CW-1:0]        r_len, r_base;
  logic                 r_s1_valid, r_s1_last, r_acc_valid, r_acc_last;

  logic [CW-1:0]        w_len;
  logic                 w_accept, w_last_beat;
  logic [data_size-1:0] w_t_val;
  logic [IW-1:0]        w_t_idx;

  // Strict "a beats b"; equal values never win, so the earlier index is kept on ties.
  // Sign-magnitude zeros of either sign are equal.
  function automatic logic gt(input logic [data_size-1:0] a, input logic [data_size-1:0] b);
    logic [data_size-2:0] ma, mb;
    ma = a[data_size-2:0];
    mb = b[data_size-2:0];
    if (signed_mode) return $signed(a) > $signed(b);
    if (ma == '0 && mb == '0) return 1'b0;
    if (a[data_size-1] != b[data_size-1]) return !a[data_size-1];
    return a[data_size-1] ? (ma < mb) : (ma > mb);
  endfunction

  assign w_len = (length_i == '0 || length_i > LW'(number_of_data)) ? CW'(number_of_data) : CW'(length_i);
  assign w_accept = r_ready && valid_i;
  assign w_last_beat = (r_base + CW'(lanes)) >= r_len;

  // Lane reduction of the current beat; lane 0 is always in range while collecting,
  // lanes past the vector length are masked out.
  always_comb begin
    w_t_val = data_i[data_size-1:0];
    w_t_idx = IW'(r_base);
    for (int k = 1; k < lanes; k++)
      if ((r_base + CW'(k)) < r_len && gt(data_i[k*data_size +: data_size], w_t_val)) begin
        w_t_val = data_i[k*data_size +: data_size];
        w_t_idx = IW'(r_base + CW'(k));
      end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= IDLE;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_max       <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_base      <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_val    <= '0;
      r_s1_idx    <= '0;
      r_acc_valid <= 1'b0;
      r_acc_last  <= 1'b0;
      r_acc_val   <= '0;
      r_acc_idx   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_last  <= w_accept && w_last_beat;
      if (w_accept) begin
        r_s1_val <= w_t_val;
        r_s1_idx <= w_t_idx;
      end
      r_acc_last <= r_s1_valid && r_s1_last;
      if (r_s1_valid && (!r_acc_valid || gt(r_s1_val, r_acc_val))) begin
        r_acc_val <= r_s1_val;
        r_acc_idx <= r_s1_idx;
      end
      if (r_s1_valid) r_acc_valid <= 1'b1;
      case (r_state)
        IDLE, DONE:
          if (start_i) begin
            r_state     <= COLLECT;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_base      <= '0;
            r_len       <= w_len;
            r_acc_valid <= 1'b0;
          end
        COLLECT:
          if (w_accept) begin
            r_base <= r_base + CW'(lanes);
            if (w_last_beat) begin
              r_state <= DRAIN;
              r_ready <= 1'b0;
            end
          end
        DRAIN:
          if (r_acc_last) begin
            r_max   <= r_acc_val;
            r_idx   <= r_acc_idx;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready_o         = r_ready;
  assign data_max_o      = r_max;
  assign index_max_o     = r_idx;
  assign max_tree_done_o = r_done;
endmodule

// File: tb/tb_max_search_stream.sv
// tb_max_search_stream: drives one stimulus stream into a two's-complement and a sign-magnitude instance and scoreboards both.
module tb_max_search_stream;
  localparam int DS = 16;
  localparam int N  = 10;
  localparam int L  = 2;
  localparam int LW = $clog2(N + 1);
  localparam int IW = $clog2(N);

  logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0, valid = 1'b0;
  logic [LW-1:0]   len = '0;
  logic [L*DS-1:0] data = '0;
  logic            rdy_tc, rdy_sm, done_tc, done_sm;
  logic [DS-1:0]   max_tc, max_sm;
  logic [IW-1:0]   idx_tc, idx_sm;

  int checks = 0, errors = 0, cyc = 0;

  typedef struct {
    logic [DS-1:0] tc_max;
    logic [DS-1:0] sm_max;
    int            tc_idx;
    int            sm_idx;
    int            at;
  } exp_t;

  exp_t          q[$];
  logic [DS-1:0] el[16];
  logic [DS-1:0] last_tc = '0, last_sm = '0;

  max_search_stream #(.data_size(DS), .number_of_data(N), .lanes(L), .signed_mode(1'b1)) u_tc (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start), .length_i(len), .valid_i(valid), .data_i(data),
    .ready_o(rdy_tc), .data_max_o(max_tc), .index_max_o(idx_tc), .max_tree_done_o(done_tc));

  max_search_stream #(.data_size(DS), .number_of_data(N), .lanes(L), .signed_mode(1'b0)) u_sm (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start), .length_i(len), .valid_i(valid), .data_i(data),
    .ready_o(rdy_sm), .data_max_o(max_sm), .index_max_o(idx_sm), .max_tree_done_o(done_sm));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint key(input logic [DS-1:0] v, input bit sgn);
    if (sgn) return longint'($signed(v));
    return v[DS-1] ? -longint'(v[DS-2:0]) : longint'(v[DS-2:0]);
  endfunction

  function automatic int ref_idx(input int n, input bit sgn);
    int b = 0;
    for (int i = 1; i < n; i++)
      if (key(el[i], sgn) > key(el[b], sgn)) b = i;
    return b;
  endfunction

  task automatic fill_bait(input int n);
    for (int i = n; i < 16; i++) el[i] = 16'h7FFF;
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++)
      el[i] = ($urandom % 2) ? (DS'($urandom_range(0, 3)) | (($urandom % 2) ? 16'h8000 : 16'h0000))
                             : DS'($urandom_range(0, 16'h7FFE)) | (($urandom % 2) ? 16'h8000 : 16'h0000);
    fill_bait(n);
  endtask

  task automatic run(input int ln, input bit gaps);
    int   n, nb, at, t;
    exp_t e;
    n  = (ln == 0 || ln > N) ? N : ln;
    nb = (n + L - 1) / L;
    at = 0;
    start = 1'b1;
    len = LW'(ln);
    valid = 1'b0;
    data = $urandom;
    @(negedge clk);
    start = 1'b0;
    chk("ready_after_start", rdy_tc, 1);
    chk("done_cleared", done_tc, 0);
    chk("hold_tc_max", max_tc, last_tc);
    chk("hold_sm_max", max_sm, last_sm);
    for (int b = 0; b < nb; b++) begin
      if (gaps)
        repeat ($urandom_range(0, 2)) begin
          valid = 1'b0;
          data = $urandom;
          start = ($urandom % 3) == 0;
          len = LW'(1);
          @(negedge clk);
          start = 1'b0;
        end
      chk("ready_beat", rdy_tc, 1);
      valid = 1'b1;
      for (int k = 0; k < L; k++) data[k*DS +: DS] = el[b*L + k];
      at = cyc + 3;
      @(negedge clk);
    end
    valid = 1'b0;
    data = $urandom;
    chk("ready_drop", rdy_tc, 0);
    e.tc_idx = ref_idx(n, 1'b1);
    e.sm_idx = ref_idx(n, 1'b0);
    e.tc_max = el[e.tc_idx];
    e.sm_max = el[e.sm_idx];
    e.at = at;
    q.push_back(e);
    last_tc = e.tc_max;
    last_sm = e.sm_max;
    t = 0;
    while (!done_tc && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", done_tc, 1);
  endtask

  initial begin
    bit   pd;
    exp_t e;
    pd = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) pd = 1'b0;
      else begin
        if (done_tc && !pd) begin
          if (q.size() == 0) chk("unexpected_done", q.size(), 1);
          else begin
            e = q.pop_front();
            chk("tc_max", max_tc, e.tc_max);
            chk("tc_idx", idx_tc, e.tc_idx);
            chk("sm_max", max_sm, e.sm_max);
            chk("sm_idx", idx_sm, e.sm_idx);
            chk("sm_done", done_sm, 1);
            chk("done_latency", cyc, e.at);
          end
        end
        pd = done_tc;
      end
    end
  end

  initial begin
    int v10[10];
    @(negedge clk);
    chk("rst_ready", rdy_tc, 0);
    chk("rst_done", done_tc, 0);
    chk("rst_max", max_tc, 0);
    chk("rst_idx", idx_tc, 0);
    chk("rst_sm_max", max_sm, 0);
    chk("rst_sm_done", done_sm, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    v10 = '{-3, 5, 7, -1, 7, 2, 0, -8, 6, 1};
    for (int i = 0; i < 10; i++) el[i] = DS'(v10[i]);
    fill_bait(10);
    run(10, 1'b0);

    el[0] = 16'h8005; el[1] = 16'h8002; el[2] = 16'h8009; el[3] = 16'h8000;
    fill_bait(4);
    run(4, 1'b0);
    el[1] = 16'h0000;
    run(4, 1'b0);

    fill_rand(5);
    run(5, 1'b0);
    fill_rand(10);
    run(0, 1'b0);
    fill_rand(10);
    run(15, 1'b0);

    for (int v = 0; v < 20; v++) begin
      int ln;
      ln = $urandom_range(0, 15);
      fill_rand((ln == 0 || ln > N) ? N : ln);
      run(ln, 1'b1);
    end

    fill_rand(10);
    start = 1'b1;
    len = LW'(10);
    @(negedge clk);
    start = 1'b0;
    valid = 1'b1;
    data = {el[1], el[0]};
    @(negedge clk);
    data = {el[3], el[2]};
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ready", rdy_tc, 0);
    chk("arst_done", done_tc, 0);
    chk("arst_tc_max", max_tc, 0);
    chk("arst_tc_idx", idx_tc, 0);
    chk("arst_sm_max", max_sm, 0);
    chk("arst_sm_ready", rdy_sm, 0);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_tc = '0;
    last_sm = '0;
    @(negedge clk);
    el[0] = 16'd1;
    el[1] = 16'd2;
    fill_bait(2);
    run(2, 1'b0);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end
endmodule
